// File: rtl/bypass_network_pkg.sv
// Shared types and helpers for the Execute-stage operand bypass network.
package bypass_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_RADDR_W = 5;
  localparam int SEL_RF      = 0;

  typedef struct packed {
    logic                   valid;
    logic [DEF_RADDR_W-1:0] rd;
    logic [DEF_XLEN-1:0]    data;
    logic                   pending;
  } hist_entry_t;

  // Select code 0 is the register file, 1..DEPTH name history entries.
  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bypass_network_if.sv
// Bundle between the Execute stage and the bypass network.
interface bypass_network_if #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int NSRC    = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
);
  localparam int SEL_W = bypass_pkg::sel_width(DEPTH);

  logic                      flush;
  logic                      wr_valid;
  logic [RADDR_W-1:0]        wr_rd;
  logic [XLEN-1:0]           wr_data;
  logic                      wr_pending;
  logic                      ld_valid;
  logic [XLEN-1:0]           ld_data;
  logic [NSRC*RADDR_W-1:0]   src_addr;
  logic [NSRC*XLEN-1:0]      src_rf_data;
  logic [NSRC*XLEN-1:0]      opnd;
  logic [NSRC*SEL_W-1:0]     opnd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output flush, wr_valid, wr_rd, wr_data, wr_pending, ld_valid, ld_data,
           src_addr, src_rf_data,
    input  opnd, opnd_sel, stall, stall_cnt
  );

  modport slave (
    input  flush, wr_valid, wr_rd, wr_data, wr_pending, ld_valid, ld_data,
           src_addr, src_rf_data,
    output opnd, opnd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/bypass_network_lookup.sv
// Priority comparator for one source operand: youngest matching history entry wins.
module bypass_lookup
  import bypass_pkg::*;
#(
  parameter int  XLEN    = DEF_XLEN,
  parameter int  RADDR_W = DEF_RADDR_W,
  parameter int  DEPTH   = 2,
  parameter type entry_t = hist_entry_t,
  parameter int  SEL_W   = sel_width(DEPTH)
) (
  input  entry_t             hist_i [DEPTH],
  input  logic [RADDR_W-1:0] src_i,
  input  logic [XLEN-1:0]    rf_data_i,
  output logic [XLEN-1:0]    opnd_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               stall_req_o
);

  // Scan oldest to youngest so the last hit written is the youngest match; x0 never matches.
  always_comb begin
    opnd_o      = rf_data_i;
    sel_o       = SEL_W'(SEL_RF);
    stall_req_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hist_i[k].valid && (hist_i[k].rd == src_i) && (src_i != '0)) begin
        sel_o       = SEL_W'(k + 1);
        stall_req_o = hist_i[k].pending;
        opnd_o      = hist_i[k].pending ? rf_data_i : hist_i[k].data;
      end
    end
  end

endmodule

// File: rtl/bypass_network.sv
// Operand bypass network: registered write history, per-source forwarding and
// load-use stall detection with a saturating stall-cycle counter.
module bypass_network
  import bypass_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int NSRC    = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
) (
  input logic              clk,
  input logic              reset,
  bypass_network_if.slave  bus
);

  localparam int SEL_W = sel_width(DEPTH);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
    logic               pending;
  } entry_t;

  entry_t               hist_q [DEPTH];
  entry_t               hist_d [DEPTH];
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;
  logic [XLEN-1:0]      opnd_w [NSRC];
  logic [SEL_W-1:0]     sel_w [NSRC];
  logic                 stall_req_w [NSRC];
  logic                 stall_w;
  logic                 fill_w;
  logic [NSRC*XLEN-1:0] opnd_flat;
  logic [NSRC*SEL_W-1:0] sel_flat;

  assign fill_w = bus.ld_valid && hist_q[0].valid && hist_q[0].pending;

  // Unconditional shift; returning load data patches the entry as it moves to index 1.
  always_comb begin
    hist_d[0] = entry_t'{valid: bus.wr_valid, rd: bus.wr_rd,
                         data: bus.wr_data, pending: bus.wr_pending};
    for (int k = 1; k < DEPTH; k++) begin
      hist_d[k] = hist_q[k-1];
      if ((k == 1) && fill_w) begin
        hist_d[k].data    = bus.ld_data;
        hist_d[k].pending = 1'b0;
      end
    end
    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_d[k] = '0;
      end
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNT_W'(stall_w && !(&stall_cnt_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    bypass_lookup #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W),
      .DEPTH   (DEPTH),
      .entry_t (entry_t),
      .SEL_W   (SEL_W)
    ) u_lookup (
      .hist_i      (hist_q),
      .src_i       (bus.src_addr[i*RADDR_W +: RADDR_W]),
      .rf_data_i   (bus.src_rf_data[i*XLEN +: XLEN]),
      .opnd_o      (opnd_w[i]),
      .sel_o       (sel_w[i]),
      .stall_req_o (stall_req_w[i])
    );
  end

  always_comb begin
    opnd_flat = '0;
    sel_flat  = '0;
    stall_w   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      opnd_flat[i*XLEN +: XLEN]  = opnd_w[i];
      sel_flat[i*SEL_W +: SEL_W] = sel_w[i];
      stall_w                    = stall_w | stall_req_w[i];
    end
  end

  assign bus.opnd      = opnd_flat;
  assign bus.opnd_sel  = sel_flat;
  assign bus.stall     = stall_w;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
